// File: rtl/membus_arbiter.sv
// membus_arbiter: round-robin ibus/dbus arbiter onto one MemBus with stall lock
// and an in-order tag FIFO that routes read responses back to their issuer.
module membus_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter bit DBUS_FIRST      = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ibus_cmd_valid,
    output logic        ibus_cmd_ready,
    input  logic [31:0] ibus_cmd_payload_address,
    output logic        ibus_rsp_valid,
    input  logic        ibus_rsp_ready,
    output logic [31:0] ibus_rsp_payload_rdata,
    input  logic        dbus_cmd_valid,
    output logic        dbus_cmd_ready,
    input  logic [31:0] dbus_cmd_payload_address,
    input  logic        dbus_cmd_payload_write,
    input  logic [31:0] dbus_cmd_payload_wdata,
    input  logic [3:0]  dbus_cmd_payload_wmask,
    output logic        dbus_rsp_valid,
    input  logic        dbus_rsp_ready,
    output logic [31:0] dbus_rsp_payload_rdata,
    output logic        mem_cmd_valid,
    input  logic        mem_cmd_ready,
    output logic [31:0] mem_cmd_payload_address,
    output logic        mem_cmd_payload_write,
    output logic [31:0] mem_cmd_payload_wdata,
    output logic [3:0]  mem_cmd_payload_wmask,
    input  logic        mem_rsp_valid,
    output logic        mem_rsp_ready,
    input  logic [31:0] mem_rsp_payload_rdata
);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam logic [PW:0]   MAX_CNT = MAX_OUTSTANDING[PW:0];
    localparam logic [PW:0]   CNT_ONE = 1;
    localparam logic [PW-1:0] PTR_ONE = 1;

    logic          tag_q [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          lock_q, lock_d, lock_id_q, lock_id_d, rr_q, rr_d;
    logic          not_full, empty, head, i_elig, d_elig, sel, gnt_v, hs, push, pop;

    // Fullness uses the registered count, so a same-cycle pop never unblocks a read
    assign not_full = count_q < MAX_CNT;
    assign empty    = count_q == '0;
    assign head     = tag_q[rd_ptr_q];
    assign i_elig   = ibus_cmd_valid && not_full;
    assign d_elig   = dbus_cmd_valid && (dbus_cmd_payload_write || not_full);

    always_comb begin
        sel   = lock_q ? lock_id_q : (i_elig && d_elig) ? rr_q : d_elig;
        gnt_v = sel ? d_elig : i_elig;
        hs    = gnt_v && mem_cmd_ready;
        push  = hs && !(sel && dbus_cmd_payload_write);
        pop   = mem_rsp_valid && mem_rsp_ready;
    end

    assign mem_cmd_valid           = gnt_v;
    assign mem_cmd_payload_address = sel ? dbus_cmd_payload_address : ibus_cmd_payload_address;
    assign mem_cmd_payload_write   = sel && dbus_cmd_payload_write;
    assign mem_cmd_payload_wdata   = sel ? dbus_cmd_payload_wdata : '0;
    assign mem_cmd_payload_wmask   = sel ? dbus_cmd_payload_wmask : '0;
    assign ibus_cmd_ready          = gnt_v && !sel && mem_cmd_ready;
    assign dbus_cmd_ready          = gnt_v && sel && mem_cmd_ready;

    assign mem_rsp_ready          = !empty && (head ? dbus_rsp_ready : ibus_rsp_ready);
    assign ibus_rsp_valid         = mem_rsp_valid && !empty && !head;
    assign dbus_rsp_valid         = mem_rsp_valid && !empty && head;
    assign ibus_rsp_payload_rdata = mem_rsp_payload_rdata;
    assign dbus_rsp_payload_rdata = mem_rsp_payload_rdata;

    always_comb begin
        lock_d    = hs ? 1'b0 : gnt_v ? 1'b1 : lock_q;
        lock_id_d = gnt_v ? sel : lock_id_q;
        rr_d      = hs ? !sel : rr_q;
        wr_ptr_d  = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d   = (push && !pop) ? count_q + CNT_ONE : (pop && !push) ? count_q - CNT_ONE : count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
            rr_q      <= DBUS_FIRST;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            rr_q      <= rr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) tag_q[wr_ptr_q] <= sel;
    end
endmodule

// File: tb/tb_membus_arbiter.sv
// tb_membus_arbiter: directed checks of arbitration, lock, full FIFO, response routing and reset.
module tb_membus_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        ibus_cmd_valid, ibus_cmd_ready, ibus_rsp_valid, ibus_rsp_ready;
    logic [31:0] ibus_cmd_payload_address, ibus_rsp_payload_rdata;
    logic        dbus_cmd_valid, dbus_cmd_ready, dbus_cmd_payload_write, dbus_rsp_valid, dbus_rsp_ready;
    logic [31:0] dbus_cmd_payload_address, dbus_cmd_payload_wdata, dbus_rsp_payload_rdata;
    logic [3:0]  dbus_cmd_payload_wmask;
    logic        mem_cmd_valid, mem_cmd_ready, mem_cmd_payload_write, mem_rsp_valid, mem_rsp_ready;
    logic [31:0] mem_cmd_payload_address, mem_cmd_payload_wdata, mem_rsp_payload_rdata;
    logic [3:0]  mem_cmd_payload_wmask;
    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    membus_arbiter #(.MAX_OUTSTANDING(4), .DBUS_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset),
        .ibus_cmd_valid(ibus_cmd_valid), .ibus_cmd_ready(ibus_cmd_ready),
        .ibus_cmd_payload_address(ibus_cmd_payload_address),
        .ibus_rsp_valid(ibus_rsp_valid), .ibus_rsp_ready(ibus_rsp_ready),
        .ibus_rsp_payload_rdata(ibus_rsp_payload_rdata),
        .dbus_cmd_valid(dbus_cmd_valid), .dbus_cmd_ready(dbus_cmd_ready),
        .dbus_cmd_payload_address(dbus_cmd_payload_address),
        .dbus_cmd_payload_write(dbus_cmd_payload_write),
        .dbus_cmd_payload_wdata(dbus_cmd_payload_wdata),
        .dbus_cmd_payload_wmask(dbus_cmd_payload_wmask),
        .dbus_rsp_valid(dbus_rsp_valid), .dbus_rsp_ready(dbus_rsp_ready),
        .dbus_rsp_payload_rdata(dbus_rsp_payload_rdata),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_payload_address(mem_cmd_payload_address),
        .mem_cmd_payload_write(mem_cmd_payload_write),
        .mem_cmd_payload_wdata(mem_cmd_payload_wdata),
        .mem_cmd_payload_wmask(mem_cmd_payload_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
        .mem_rsp_payload_rdata(mem_rsp_payload_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Inputs change 1ns after the rising edge; checks run 2ns later, well before the next edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, "_mcv"}, 32'(mem_cmd_valid), 0);
        chk({tag, "_icr"}, 32'(ibus_cmd_ready), 0);
        chk({tag, "_dcr"}, 32'(dbus_cmd_ready), 0);
        chk({tag, "_mrr"}, 32'(mem_rsp_ready), 0);
        chk({tag, "_irv"}, 32'(ibus_rsp_valid), 0);
        chk({tag, "_drv"}, 32'(dbus_rsp_valid), 0);
    endtask

    initial begin
        reset = 1'b1;
        ibus_cmd_valid = 0; ibus_cmd_payload_address = 0; ibus_rsp_ready = 0;
        dbus_cmd_valid = 0; dbus_cmd_payload_address = 0; dbus_cmd_payload_write = 0;
        dbus_cmd_payload_wdata = 0; dbus_cmd_payload_wmask = 0; dbus_rsp_ready = 0;
        mem_cmd_ready = 0; mem_rsp_valid = 0; mem_rsp_payload_rdata = 0;
        tick(); tick();
        reset = 1'b0;
        #2 idle_outputs("reset");

        // Tie after reset: dbus first, then ibus; responses return in issue order
        ibus_cmd_valid = 1; ibus_cmd_payload_address = 32'h200;
        dbus_cmd_valid = 1; dbus_cmd_payload_address = 32'h100; mem_cmd_ready = 1;
        #2 chk("tie_addr0", mem_cmd_payload_address, 32'h100);
        chk("tie_dcr0", 32'(dbus_cmd_ready), 1);
        chk("tie_icr0", 32'(ibus_cmd_ready), 0);
        tick(); dbus_cmd_valid = 0;
        #2 chk("tie_addr1", mem_cmd_payload_address, 32'h200);
        chk("tie_icr1", 32'(ibus_cmd_ready), 1);
        tick(); ibus_cmd_valid = 0;
        mem_rsp_valid = 1; mem_rsp_payload_rdata = 32'hAAAA; ibus_rsp_ready = 1; dbus_rsp_ready = 1;
        #2 chk("tie_rsp0_drv", 32'(dbus_rsp_valid), 1);
        chk("tie_rsp0_irv", 32'(ibus_rsp_valid), 0);
        chk("tie_rsp0_data", dbus_rsp_payload_rdata, 32'hAAAA);
        tick(); mem_rsp_payload_rdata = 32'hBBBB;
        #2 chk("tie_rsp1_irv", 32'(ibus_rsp_valid), 1);
        chk("tie_rsp1_drv", 32'(dbus_rsp_valid), 0);
        chk("tie_rsp1_data", ibus_rsp_payload_rdata, 32'hBBBB);
        tick(); mem_rsp_valid = 0;
        #2 chk("tie_empty_mrr", 32'(mem_rsp_ready), 0);

        // Lock: ibus stalled 3 cycles; dbus (favoured by rr) must wait
        ibus_cmd_valid = 1; ibus_cmd_payload_address = 32'h40; mem_cmd_ready = 0;
        #2 chk("lock_addr0", mem_cmd_payload_address, 32'h40);
        tick(); dbus_cmd_valid = 1; dbus_cmd_payload_address = 32'h80;
        #2 chk("lock_addr1", mem_cmd_payload_address, 32'h40);
        chk("lock_dcr1", 32'(dbus_cmd_ready), 0);
        tick();
        #2 chk("lock_addr2", mem_cmd_payload_address, 32'h40);
        tick(); mem_cmd_ready = 1;
        #2 chk("lock_addr3", mem_cmd_payload_address, 32'h40);
        chk("lock_icr3", 32'(ibus_cmd_ready), 1);
        chk("lock_dcr3", 32'(dbus_cmd_ready), 0);
        tick(); ibus_cmd_valid = 0;
        #2 chk("lock_daddr", mem_cmd_payload_address, 32'h80);
        chk("lock_dcr4", 32'(dbus_cmd_ready), 1);
        tick(); dbus_cmd_valid = 0; mem_rsp_valid = 1;
        #2 chk("lock_rsp_irv", 32'(ibus_rsp_valid), 1);
        tick();
        #2 chk("lock_rsp_drv", 32'(dbus_rsp_valid), 1);
        tick(); mem_rsp_valid = 0;

        // Full: four ibus reads fill the FIFO
        ibus_cmd_valid = 1;
        for (int i = 0; i < 4; i++) begin
            ibus_cmd_payload_address = 32'h1000 + 32'(i * 4);
            #2 chk("full_icr", 32'(ibus_cmd_ready), 1);
            tick();
        end
        ibus_cmd_payload_address = 32'h1010;
        #2 chk("full_mcv", 32'(mem_cmd_valid), 0);
        chk("full_icr5", 32'(ibus_cmd_ready), 0);
        dbus_cmd_valid = 1; dbus_cmd_payload_write = 1; dbus_cmd_payload_address = 32'h300;
        dbus_cmd_payload_wmask = 4'hF; dbus_cmd_payload_wdata = 32'hDEADBEEF;
        #2 chk("full_wr_mcv", 32'(mem_cmd_valid), 1);
        chk("full_wr_addr", mem_cmd_payload_address, 32'h300);
        chk("full_wr_write", 32'(mem_cmd_payload_write), 1);
        chk("full_wr_wmask", 32'(mem_cmd_payload_wmask), 32'hF);
        chk("full_wr_wdata", mem_cmd_payload_wdata, 32'hDEADBEEF);
        chk("full_wr_dcr", 32'(dbus_cmd_ready), 1);
        tick(); dbus_cmd_valid = 0; dbus_cmd_payload_write = 0; mem_rsp_valid = 1;
        #2 chk("full_pop_mrr", 32'(mem_rsp_ready), 1);
        chk("full_pop_icr", 32'(ibus_cmd_ready), 0);
        tick(); mem_rsp_valid = 0;
        #2 chk("full_5th_icr", 32'(ibus_cmd_ready), 1);
        chk("full_5th_addr", mem_cmd_payload_address, 32'h1010);
        chk("full_5th_write", 32'(mem_cmd_payload_write), 0);
        tick(); ibus_cmd_valid = 0;

        // Backpressure: head=ibus, ibus not ready
        mem_rsp_valid = 1; ibus_rsp_ready = 0;
        #2 chk("bp_mrr", 32'(mem_rsp_ready), 0);
        chk("bp_irv", 32'(ibus_rsp_valid), 1);
        chk("bp_drv", 32'(dbus_rsp_valid), 0);
        tick(); mem_rsp_valid = 0; ibus_cmd_valid = 1;
        #2 chk("bp_still_full", 32'(mem_cmd_valid), 0);
        ibus_cmd_valid = 0;

        // Drain two, leaving two outstanding, then reset
        mem_rsp_valid = 1; ibus_rsp_ready = 1;
        tick(); tick(); mem_rsp_valid = 0;
        reset = 1;
        tick(); reset = 0;
        #2 idle_outputs("rst2");
        mem_rsp_valid = 1;
        #2 chk("spur_mrr", 32'(mem_rsp_ready), 0);
        chk("spur_irv", 32'(ibus_rsp_valid), 0);
        chk("spur_drv", 32'(dbus_rsp_valid), 0);
        tick(); mem_rsp_valid = 0;
        ibus_cmd_valid = 1; ibus_cmd_payload_address = 32'h500;
        dbus_cmd_valid = 1; dbus_cmd_payload_address = 32'h600;
        #2 chk("rst2_tie_addr", mem_cmd_payload_address, 32'h600);
        tick(); ibus_cmd_valid = 0; dbus_cmd_valid = 0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
